ped_crossing_ctrl: RTL and testbench
====================================

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples needed to accept a button level change (legal 1..15).
REQ-002 Parameter WALK_CYCLES, default 4: cycles walk is held (legal 1..15).
REQ-003 Parameter FLASH_CYCLES, default 4: cycles of flashing dont_walk clearance (legal 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ped_button  input  1  raw pedestrian push-button, asynchronous to clk, bouncy.
REQ-007 red_light, yellow_light, green_light  input  1 each  vehicle lamp states from the upstream traffic-light FSM.
REQ-008 walk  output  1  pedestrian WALK lamp.
REQ-009 dont_walk  output  1  pedestrian DON'T WALK lamp (solid or flashing).
REQ-010 ped_request  output  1  latched pending crossing request.
REQ-011 light_fault  output  1  vehicle lamp inputs not one-hot.

Function
REQ-012 ped_button SHALL pass through a 2-flop synchroniser before any use.
REQ-013 Debounced level SHALL update on the edge where the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive samples; any mismatch-free sample resets the stability count.
REQ-014 A one-cycle press pulse SHALL fire on each 0->1 change of the debounced level; releases generate nothing.
REQ-015 FSM states SHALL be IDLE, WAIT_RED, WALK, CLEAR, FAULT; all outputs registered (Moore, one-cycle lag from state decision).
REQ-016 IDLE: walk=0, dont_walk=1; press -> WAIT_RED and ped_request=1 on the same edge.
REQ-017 WAIT_RED: outputs as IDLE; transition to WALK only on a red rising edge (red_light=1 and registered previous red_light=0); red already high at request time SHALL NOT start WALK.
REQ-018 WALK: walk=1, dont_walk=0 for exactly WALK_CYCLES cycles; ped_request cleared on entry; then -> CLEAR.
REQ-019 CLEAR: walk=0, dont_walk alternates 1,0,1,0... starting at 1, for exactly FLASH_CYCLES cycles; then -> IDLE.
REQ-020 red_light=0 while in WALK or CLEAR SHALL force IDLE (walk=0, dont_walk=1 next cycle), abandoning the remaining count.
REQ-021 Presses in WAIT_RED, WALK, CLEAR or FAULT SHALL be ignored and not queued.
REQ-022 Lamp inputs not exactly one-hot in any cycle SHALL force FAULT from every state: walk=0, dont_walk=1, light_fault=1, ped_request=0.
REQ-023 FAULT exits to IDLE only when inputs are one-hot with red_light=1; light_fault clears on that edge.
REQ-024 Fault detection SHALL take priority over every other transition in the same cycle; red-drop (REQ-020) takes priority over count expiry.
REQ-025 Phase counters SHALL be 4 bits, load N-1 on state entry, decrement to 0; no wrap.

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, walk=0, dont_walk=1, ped_request=0, light_fault=0, synchroniser, debounce level and counters to 0, previous red to 0.
REQ-027 Reset asserted mid-WALK or CLEAR SHALL take effect immediately without waiting for clk.

Structure
REQ-028 State enum type ped_state_t (3-bit) and default timing constants SHALL live in shared package ped_pkg.
REQ-029 Synchroniser, debouncer and press-pulse generator SHALL be sub-module ped_debounce (ports clk, reset, btn_raw, press).

Verification (defaults)
REQ-030 Green on, button held high 10 cycles -> one press pulse, ped_request=1; at red rising edge walk=1 exactly 4 cycles, dont_walk 1,0,1,0, then solid 1.
REQ-031 Button toggling every 2 cycles for 12 cycles then low -> no press, ped_request stays 0.
REQ-032 Clean press while red already high -> no WALK this red phase; WALK starts on the next red rising edge.
REQ-033 red_light drops in 2nd WALK cycle -> next cycle walk=0, dont_walk=1, state IDLE.
REQ-034 red and green both high one cycle -> light_fault=1, walk=0; lights return one-hot with red -> light_fault=0, IDLE.
REQ-035 Reset asserted mid-WALK between clock edges -> walk=0, dont_walk=1, ped_request=0 immediately.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and default timing for the pedestrian crossing controller.
package ped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RED = 3'd1,
    ST_WALK     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_FAULT    = 3'd4
  } ped_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_WALK_CYCLES     = 4;
  localparam int unsigned DEF_FLASH_CYCLES    = 4;
  localparam int unsigned PHASE_CNT_W         = 4;

  typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

  // True when exactly one of the three vehicle lamps is lit.
  function automatic logic lamps_one_hot(input logic r, input logic y, input logic g);
    return (r ^ y ^ g) & ~(r & y & g);
  endfunction

  function automatic phase_cnt_t cnt_load(input int unsigned n);
    return phase_cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Lamp inputs and pedestrian outputs of the crossing controller.
interface ped_crossing_ctrl_if;

  logic ped_button;
  logic red_light;
  logic yellow_light;
  logic green_light;
  logic walk;
  logic dont_walk;
  logic ped_request;
  logic light_fault;

  modport master (
    output ped_button, red_light, yellow_light, green_light,
    input  walk, dont_walk, ped_request, light_fault
  );

  modport slave (
    input  ped_button, red_light, yellow_light, green_light,
    output walk, dont_walk, ped_request, light_fault
  );

endinterface

// File: rtl/ped_debounce.sv
// Button synchroniser, stability-count debouncer and press-edge pulse.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       level_prev_q;
  phase_cnt_t stab_q, stab_d;

  // NOTE: non-blocking assignments make sync2_q take the old sync1_q, giving two real flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    stab_d  = '0;
    if (sync2_q != level_q) begin
      if (stab_q == phase_cnt_t'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        stab_d = stab_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      stab_q       <= '0;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      stab_q       <= stab_d;
    end
  end

  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: request latch, red-edge walk start,
// timed walk and flashing clearance, lamp-fault lockout.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int unsigned FLASH_CYCLES    = DEF_FLASH_CYCLES
) (
  input logic                clk,
  input logic                reset,
  ped_crossing_ctrl_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
      WALK_CYCLES < 1 || WALK_CYCLES > 15 ||
      FLASH_CYCLES < 1 || FLASH_CYCLES > 15) begin : g_param_check
    $error("ped_crossing_ctrl: timing parameters must lie in 1..15");
  end

  logic       press;
  logic       lamps_ok;
  logic       red_rise;
  logic       red_prev_q;
  ped_state_t state_q, state_d;
  phase_cnt_t cnt_q, cnt_d;
  phase_cnt_t flash_elapsed;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic       ped_request_q, ped_request_d;
  logic       light_fault_q, light_fault_d;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(bus.ped_button),
    .press  (press)
  );

  assign lamps_ok = lamps_one_hot(bus.red_light, bus.yellow_light, bus.green_light);
  assign red_rise = bus.red_light & ~red_prev_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    walk_d        = 1'b0;
    dont_walk_d   = 1'b1;
    ped_request_d = 1'b0;
    light_fault_d = 1'b0;

    if (!lamps_ok) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press) state_d = ST_WAIT_RED;
        end
        ST_WAIT_RED: begin
          if (red_rise) begin
            state_d = ST_WALK;
            cnt_d   = cnt_load(WALK_CYCLES);
          end
        end
        ST_WALK: begin
          // Losing red abandons the crossing before any count expiry.
          if (!bus.red_light) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_CLEAR;
            cnt_d   = cnt_load(FLASH_CYCLES);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_CLEAR: begin
          if (!bus.red_light || cnt_q == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_FAULT: begin
          if (bus.red_light) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the state being entered so they register on the decision edge.
    flash_elapsed = cnt_load(FLASH_CYCLES) - cnt_d;
    unique case (state_d)
      ST_WAIT_RED: ped_request_d = 1'b1;
      ST_WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      ST_CLEAR:    dont_walk_d   = ~flash_elapsed[0];
      ST_FAULT:    light_fault_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      red_prev_q    <= 1'b0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      ped_request_q <= 1'b0;
      light_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      red_prev_q    <= bus.red_light;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      ped_request_q <= ped_request_d;
      light_fault_q <= light_fault_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dont_walk_q;
  assign bus.ped_request = ped_request_q;
  assign bus.light_fault = light_fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scenario and randomized checks of ped_crossing_ctrl against a behavioural model.
module tb_ped_crossing_ctrl;
  import ped_pkg::*;

  localparam int DEB = 4;
  localparam int WLK = 4;
  localparam int FLS = 4;

  typedef struct packed {
    bit       r;
    bit       y;
    bit       g;
    bit       btn;
    bit [7:0] n;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  bit   drv_r, drv_y, drv_g, drv_btn;

  ped_crossing_ctrl_if bus ();

  assign bus.ped_button   = drv_btn;
  assign bus.red_light    = drv_r;
  assign bus.yellow_light = drv_y;
  assign bus.green_light  = drv_g;

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .WALK_CYCLES    (WLK),
    .FLASH_CYCLES   (FLS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt = 0;

  // Reference model: pedestrian timeline as remaining-cycle budgets.
  bit m_fault, m_waiting, m_prev_red, m_level, m_press_due;
  int m_walk_left, m_flash_left;
  bit raw_q[$];
  bit win_q[$];

  function automatic void model_reset();
    m_fault = 0; m_waiting = 0; m_prev_red = 0; m_level = 0; m_press_due = 0;
    m_walk_left = 0; m_flash_left = 0;
    raw_q = '{1'b0, 1'b0};
    win_q = {};
  endfunction

  function automatic void model_edge();
    bit onehot, s, all_diff, press_now;
    onehot    = (int'(drv_r) + int'(drv_y) + int'(drv_g)) == 1;
    press_now = m_press_due;
    if (m_fault) begin
      if (onehot && drv_r) m_fault = 0;
    end else if (!onehot) begin
      m_fault = 1; m_waiting = 0; m_walk_left = 0; m_flash_left = 0;
    end else if (m_walk_left > 0) begin
      if (!drv_r) m_walk_left = 0;
      else begin
        m_walk_left--;
        if (m_walk_left == 0) m_flash_left = FLS;
      end
    end else if (m_flash_left > 0) begin
      if (!drv_r) m_flash_left = 0;
      else m_flash_left--;
    end else if (m_waiting) begin
      if (drv_r && !m_prev_red) begin
        m_waiting = 0;
        m_walk_left = WLK;
      end
    end else if (press_now) begin
      m_waiting = 1;
    end
    m_prev_red = drv_r;
    // Button: two-sample synchroniser delay, then a window of DEB samples.
    raw_q.push_back(drv_btn);
    s = raw_q.pop_front();
    win_q.push_back(s);
    if (win_q.size() > DEB) void'(win_q.pop_front());
    m_press_due = 0;
    if (win_q.size() == DEB) begin
      all_diff = 1;
      foreach (win_q[i]) if (win_q[i] == m_level) all_diff = 0;
      if (all_diff) begin
        m_level = ~m_level;
        m_press_due = m_level;
      end
    end
  endfunction

  function automatic logic [3:0] exp_vec();
    bit w, dw;
    w  = !m_fault && (m_walk_left > 0);
    if (m_fault || m_walk_left == 0 && m_flash_left == 0) dw = 1;
    else if (m_walk_left > 0) dw = 0;
    else dw = ((FLS - m_flash_left) % 2) == 0;
    return {w, dw, m_waiting, m_fault};
  endfunction

  function automatic logic [3:0] outs();
    return {bus.walk, bus.dont_walk, bus.ped_request, bus.light_fault};
  endfunction

  task automatic set_lights(input bit r, input bit y, input bit g);
    drv_r = r; drv_y = y; drv_g = g;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    cyc++;
    if (dut.u_debounce.press === 1'b1) press_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_lights(0, 0, 1);
    drv_btn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.walk !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b want 0", bus.walk); end
    checks++; if (bus.dont_walk !== 1'b1) begin errors++; $display("FAIL reset_dont_walk: got %b want 1", bus.dont_walk); end
    checks++; if (bus.ped_request !== 1'b0) begin errors++; $display("FAIL reset_ped_request: got %b want 0", bus.ped_request); end
    checks++; if (bus.light_fault !== 1'b0) begin errors++; $display("FAIL reset_light_fault: got %b want 0", bus.light_fault); end
    reset = 1'b0;
  endtask

  task automatic test_press_walk();
    row_t rows[$];
    int walks = 0;
    int p0 = press_cnt;
    rows = '{'{1'b0,1'b0,1'b1,1'b1,8'd10}, '{1'b0,1'b0,1'b1,1'b0,8'd10}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL press_walk_a cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
    checks++; if (press_cnt - p0 != 1) begin errors++; $display("FAIL press_pulse_count: got %0d want 1", press_cnt - p0); end
    checks++; if (bus.ped_request !== 1'b1) begin errors++; $display("FAIL press_latched: got %b want 1", bus.ped_request); end
    rows = '{'{1'b0,1'b1,1'b0,1'b0,8'd3}, '{1'b1,1'b0,1'b0,1'b0,8'd16}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL press_walk_b cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
      walks += int'(bus.walk);
    end
    checks++; if (walks != WLK) begin errors++; $display("FAIL walk_length: got %0d want %0d", walks, WLK); end
    checks++; if (bus.dont_walk !== 1'b1) begin errors++; $display("FAIL solid_dont_walk: got %b want 1", bus.dont_walk); end
  endtask

  task automatic test_bounce();
    row_t rows[$];
    int p0 = press_cnt;
    rows = '{'{1'b0,1'b0,1'b1,1'b1,8'd2}, '{1'b0,1'b0,1'b1,1'b0,8'd2}, '{1'b0,1'b0,1'b1,1'b1,8'd2},
             '{1'b0,1'b0,1'b1,1'b0,8'd2}, '{1'b0,1'b0,1'b1,1'b1,8'd2}, '{1'b0,1'b0,1'b1,1'b0,8'd12}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL bounce cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
      checks++; if (bus.ped_request !== 1'b0) begin errors++; $display("FAIL bounce_request cyc %0d: got %b want 0", cyc, bus.ped_request); end
    end
    checks++; if (press_cnt != p0) begin errors++; $display("FAIL bounce_press: got %0d pulses want 0", press_cnt - p0); end
  endtask

  task automatic test_red_already_high();
    row_t rows[$];
    int walks = 0;
    rows = '{'{1'b1,1'b0,1'b0,1'b0,8'd3}, '{1'b1,1'b0,1'b0,1'b1,8'd8}, '{1'b1,1'b0,1'b0,1'b0,8'd12}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL red_high_a cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
      walks += int'(bus.walk);
    end
    checks++; if (walks != 0) begin errors++; $display("FAIL red_high_no_walk: got %0d walk cycles want 0", walks); end
    checks++; if (bus.ped_request !== 1'b1) begin errors++; $display("FAIL red_high_pending: got %b want 1", bus.ped_request); end
    rows = '{'{1'b0,1'b0,1'b1,1'b0,8'd3}, '{1'b0,1'b1,1'b0,1'b0,8'd2}, '{1'b1,1'b0,1'b0,1'b0,8'd14}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL red_high_b cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
      walks += int'(bus.walk);
    end
    checks++; if (walks != WLK) begin errors++; $display("FAIL red_high_next_walk: got %0d want %0d", walks, WLK); end
  endtask

  task automatic test_red_drop();
    row_t rows[$];
    rows = '{'{1'b0,1'b0,1'b1,1'b1,8'd8}, '{1'b0,1'b0,1'b1,1'b0,8'd6}, '{1'b0,1'b1,1'b0,1'b0,8'd3},
             '{1'b1,1'b0,1'b0,1'b0,8'd2}, '{1'b0,1'b0,1'b1,1'b0,8'd1}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL red_drop cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
    checks++; if (bus.walk !== 1'b0 || bus.dont_walk !== 1'b1) begin
      errors++; $display("FAIL red_drop_lamps: walk %b dont_walk %b want 0 1", bus.walk, bus.dont_walk); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL red_drop_state: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_fault();
    row_t rows[$];
    rows = '{'{1'b0,1'b0,1'b1,1'b1,8'd8}, '{1'b0,1'b0,1'b1,1'b0,8'd6}, '{1'b0,1'b1,1'b0,1'b0,8'd3},
             '{1'b1,1'b0,1'b0,1'b0,8'd2}, '{1'b1,1'b0,1'b1,1'b0,8'd1}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL fault_a cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
    checks++; if (outs() !== 4'b0101) begin errors++; $display("FAIL fault_entry: outs %b want 0101", outs()); end
    set_lights(1, 0, 0);
    tick();
    checks++; if (bus.light_fault !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL fault_exit: light_fault %b state %0d want 0 %0d", bus.light_fault, dut.state_q, ST_IDLE); end
    repeat (4) begin
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL fault_b cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
  endtask

  task automatic test_reset_mid_walk();
    row_t rows[$];
    rows = '{'{1'b0,1'b0,1'b1,1'b1,8'd8}, '{1'b0,1'b0,1'b1,1'b0,8'd6}, '{1'b0,1'b1,1'b0,1'b0,8'd3},
             '{1'b1,1'b0,1'b0,1'b0,8'd2}};
    foreach (rows[k]) for (int i = 0; i < int'(rows[k].n); i++) begin
      set_lights(rows[k].r, rows[k].y, rows[k].g); drv_btn = rows[k].btn;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL rst_walk_a cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (outs() !== 4'b0100) begin errors++; $display("FAIL async_reset: outs %b want 0100", outs()); end
    model_reset();
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL rst_walk_b cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    bit [2:0] bad[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    bit [2:0] pat;
    int color = 2, seg_left = 0, btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        color = (color + 1) % 3;
        seg_left = (color == 0) ? int'($urandom_range(3, 10)) :
                   (color == 1) ? int'($urandom_range(2, 4)) : int'($urandom_range(5, 20));
      end
      seg_left--;
      pat = (color == 0) ? 3'b001 : (color == 1) ? 3'b010 : 3'b100;
      if ($urandom_range(0, 99) < 3) pat = bad[$urandom_range(0, 4)];
      set_lights(pat[2], pat[1], pat[0]);
      if (btn_left == 0) begin
        drv_btn  = 1'($urandom_range(0, 1));
        btn_left = int'($urandom_range(1, 12));
      end
      btn_left--;
      tick();
      checks++; if (outs() !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: outs %b want %b", cyc, outs(), exp_vec()); end
      checks++; if (dut.u_debounce.press !== m_press_due) begin
        errors++; $display("FAIL random_press cyc %0d: got %b want %b", cyc, dut.u_debounce.press, m_press_due); end
    end
  endtask

  initial begin
    test_reset();
    test_press_walk();
    test_bounce();
    test_red_already_high();
    test_red_drop();
    test_fault();
    test_reset_mid_walk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
